// File: rtl/dot11_set_arb.sv
// Setting-bus write arbiter: grants one of two requesters, issues a single-cycle
// registered strobe, then enforces GAP idle cycles before the next grant.
//
// state   | meaning
// S_IDLE  | waiting for an eligible requester; grants allowed when enable=1
// S_ISSUE | set_stb asserted for the captured write
// S_GAP   | forced idle cycles after a strobe, counted down in gap_cnt
module dot11_set_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int GAP    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              busy,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              set_stb,
  output logic [ADDR_W-1:0] set_addr,
  output logic [DATA_W-1:0] set_data,
  output logic              grant_id,
  output logic [15:0]       write_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0] state;
  logic [3:0] gap_cnt;
  logic       last_grant;
  logic       elig0;
  logic       elig1;
  logic       can_grant;
  logic       pick1;
  logic       accept;

  // Host writes wait while the decoder is busy; system writes never do.
  always_comb begin
    elig0      = req0_valid & ~busy;
    elig1      = req1_valid;
    can_grant  = reset & enable & (state == S_IDLE);
    pick1      = elig1 & (~elig0 | ~last_grant);
    req1_ready = can_grant & pick1;
    req0_ready = can_grant & elig0 & ~pick1;
    accept     = req0_ready | req1_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      gap_cnt     <= 4'd0;
      set_stb     <= 1'b0;
      set_addr    <= '0;
      set_data    <= '0;
      grant_id    <= 1'b0;
      write_count <= 16'd0;
      last_grant  <= 1'b1;
    end else begin
      set_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_ISSUE;
            set_stb    <= 1'b1;
            set_addr   <= req1_ready ? req1_addr : req0_addr;
            set_data   <= req1_ready ? req1_data : req0_data;
            grant_id   <= req1_ready;
            last_grant <= req1_ready;
            if (write_count != 16'hFFFF) write_count <= write_count + 16'd1;
          end
        end
        S_ISSUE: begin
          if (GAP != 0) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt == 4'd0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot11_set_arb.sv
// Directed bench for dot11_set_arb: a GAP=2 instance and a GAP=0 instance
// share stimulus; each task checks the instance relevant to its scenario.
module tb_dot11_set_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        busy;
  logic        req0_valid;
  logic [7:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic [7:0]  req1_addr;
  logic [31:0] req1_data;

  logic        req0_ready, req1_ready, set_stb, grant_id;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [15:0] write_count;

  logic        req0_ready_z, req1_ready_z, set_stb_z, grant_id_z;
  logic [7:0]  set_addr_z;
  logic [31:0] set_data_z;
  logic [15:0] write_count_z;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  dot11_set_arb #(.ADDR_W(8), .DATA_W(32), .GAP(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .busy(busy),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .grant_id(grant_id), .write_count(write_count)
  );

  dot11_set_arb #(.ADDR_W(8), .DATA_W(32), .GAP(0)) dut_z (
    .clock(clock), .reset(reset), .enable(enable), .busy(busy),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready_z),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready_z),
    .set_stb(set_stb_z), .set_addr(set_addr_z), .set_data(set_data_z),
    .grant_id(grant_id_z), .write_count(write_count_z)
  );

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b1; busy = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; busy = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'h11; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 8'h22; req1_data = 32'h2;
    @(negedge clock);
    compared++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      mismatched++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    compared++;
    if ({set_stb, grant_id} !== 2'b00) begin
      mismatched++; $display("FAIL reset_stb_gid: got %b want 00", {set_stb, grant_id});
    end
    compared++;
    if (set_addr !== 8'h0 || set_data !== 32'h0 || write_count !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_regs: got %h/%h/%h want 0/0/0", set_addr, set_data, write_count);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_addr = 8'h01; req0_data = 32'h0;
    #1;
    compared++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      mismatched++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
    end
    @(negedge clock);
    req0_valid = 1'b0;
    compared++;
    if (set_stb !== 1'b1 || set_addr !== 8'h01 || set_data !== 32'h0 || grant_id !== 1'b0) begin
      mismatched++;
      $display("FAIL single_strobe: got stb=%b addr=%h data=%h gid=%b want 1/01/0/0",
               set_stb, set_addr, set_data, grant_id);
    end
    compared++;
    if (write_count !== 16'd1) begin
      mismatched++; $display("FAIL single_count: got %0d want 1", write_count);
    end
    @(negedge clock);
    compared++;
    if (set_stb !== 1'b0 || set_addr !== 8'h01) begin
      mismatched++; $display("FAIL single_hold: got stb=%b addr=%h want 0/01", set_stb, set_addr);
    end
  endtask

  task automatic test_contention();
    logic exp_stb;
    logic exp_gid;
    do_reset();
    req0_valid = 1'b1; req0_addr = 8'h10; req0_data = 32'hAAAA_0000;
    req1_valid = 1'b1; req1_addr = 8'h20; req1_data = 32'hBBBB_0000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      exp_stb = (i % 4 == 1);
      exp_gid = ((i / 4) % 2 == 1);
      compared++;
      if (set_stb !== exp_stb) begin
        mismatched++; $display("FAIL contend_stb[%0d]: got %b want %b", i, set_stb, exp_stb);
      end
      if (exp_stb) begin
        compared++;
        if (grant_id !== exp_gid || set_addr !== (exp_gid ? 8'h20 : 8'h10)) begin
          mismatched++;
          $display("FAIL contend_gid[%0d]: got gid=%b addr=%h want gid=%b", i, grant_id, set_addr, exp_gid);
        end
      end
    end
    compared++;
    if (write_count !== 16'd3) begin
      mismatched++; $display("FAIL contend_count: got %0d want 3", write_count);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_busy();
    do_reset();
    busy = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'h0A; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 8'h0B; req1_data = 32'hB;
    #1;
    compared++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      mismatched++; $display("FAIL busy_ready: got %b want 01", {req0_ready, req1_ready});
    end
    @(negedge clock);
    req1_valid = 1'b0;
    compared++;
    if (set_stb !== 1'b1 || grant_id !== 1'b1 || set_addr !== 8'h0B) begin
      mismatched++;
      $display("FAIL busy_req1_strobe: got stb=%b gid=%b addr=%h want 1/1/0b", set_stb, grant_id, set_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      compared++;
      if (req0_ready !== 1'b0 || set_stb !== 1'b0) begin
        mismatched++;
        $display("FAIL busy_defer[%0d]: got ready0=%b stb=%b want 0/0", i, req0_ready, set_stb);
      end
    end
    @(negedge clock);
    busy = 1'b0;
    #1;
    compared++;
    if (req0_ready !== 1'b1) begin
      mismatched++; $display("FAIL busy_release_ready: got %b want 1", req0_ready);
    end
    @(negedge clock);
    req0_valid = 1'b0;
    compared++;
    if (set_stb !== 1'b1 || grant_id !== 1'b0 || set_addr !== 8'h0A) begin
      mismatched++;
      $display("FAIL busy_req0_strobe: got stb=%b gid=%b addr=%h want 1/0/0a", set_stb, grant_id, set_addr);
    end
  endtask

  task automatic test_gap0();
    logic exp_stb;
    do_reset();
    req1_valid = 1'b1; req1_addr = 8'h33; req1_data = 32'h3;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      exp_stb = (i % 2 == 1);
      compared++;
      if (set_stb_z !== exp_stb) begin
        mismatched++; $display("FAIL gap0_stb[%0d]: got %b want %b", i, set_stb_z, exp_stb);
      end
      if (i == 3) begin
        compared++;
        if (write_count_z !== 16'd2) begin
          mismatched++; $display("FAIL gap0_count: got %0d want 2", write_count_z);
        end
      end
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req1_valid = 1'b1; req1_addr = 8'h55; req1_data = 32'h1234;
    @(negedge clock);
    req1_valid = 1'b0;
    compared++;
    if (set_stb !== 1'b1 || grant_id !== 1'b1) begin
      mismatched++; $display("FAIL midrst_pre: got stb=%b gid=%b want 1/1", set_stb, grant_id);
    end
    reset = 1'b0;
    #1;
    compared++;
    if (set_stb !== 1'b0 || grant_id !== 1'b0) begin
      mismatched++; $display("FAIL midrst_stb: got stb=%b gid=%b want 0/0", set_stb, grant_id);
    end
    compared++;
    if (set_addr !== 8'h0 || set_data !== 32'h0 || write_count !== 16'h0) begin
      mismatched++;
      $display("FAIL midrst_regs: got %h/%h/%h want 0/0/0", set_addr, set_data, write_count);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      compared++;
      if (set_stb !== 1'b0) begin
        mismatched++; $display("FAIL midrst_quiet[%0d]: got %b want 0", i, set_stb);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    req1_valid = 1'b1; req1_addr = 8'h77; req1_data = 32'h7;
    #1;
    compared++;
    if (req1_ready !== 1'b0) begin
      mismatched++; $display("FAIL enable_block_ready: got %b want 0", req1_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      compared++;
      if (set_stb !== 1'b0) begin
        mismatched++; $display("FAIL enable_block_stb[%0d]: got %b want 0", i, set_stb);
      end
    end
    enable = 1'b1;
    #1;
    compared++;
    if (req1_ready !== 1'b1) begin
      mismatched++; $display("FAIL enable_ready: got %b want 1", req1_ready);
    end
    @(negedge clock);
    req1_valid = 1'b0;
    enable = 1'b0;
    compared++;
    if (set_stb !== 1'b1 || set_addr !== 8'h77) begin
      mismatched++; $display("FAIL enable_strobe: got stb=%b addr=%h want 1/77", set_stb, set_addr);
    end
    enable = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.write_count = 16'hFFFD;
    @(negedge clock);
    release dut.write_count;
    req1_valid = 1'b1; req1_addr = 8'h99; req1_data = 32'h9;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clock);
      if (i == 1) begin
        compared++;
        if (write_count !== 16'hFFFE) begin
          mismatched++; $display("FAIL sat_first: got %h want fffe", write_count);
        end
      end
      if (i == 5 || i == 9 || i == 13) begin
        compared++;
        if (write_count !== 16'hFFFF || set_stb !== 1'b1) begin
          mismatched++;
          $display("FAIL sat_hold[%0d]: got cnt=%h stb=%b want ffff/1", i, write_count, set_stb);
        end
      end
    end
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_busy();
    test_gap0();
    test_reset_mid();
    test_enable();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dot11_set_arb.md
DOT11_SET_ARB -- requirements
Module: dot11_set_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, setting-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, setting-bus data width.
REQ-003 SHALL have parameter GAP, default 2, range 0..15, idle cycles forced after each strobe.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low (0 = reset), released synchronously by integrator.
REQ-006 SHALL have port enable  input  1  1 = new grants allowed.
REQ-007 SHALL have port busy  input  1  decoder not in idle/search state; defers host writes.
REQ-008 SHALL have ports req0_valid/req0_addr/req0_data  input  1/ADDR_W/DATA_W  host requester, deferrable.
REQ-009 SHALL have port req0_ready  output  1  high in the accept cycle of requester 0.
REQ-010 SHALL have ports req1_valid/req1_addr/req1_data  input  1/ADDR_W/DATA_W  system requester, never deferred.
REQ-011 SHALL have port req1_ready  output  1  high in the accept cycle of requester 1.
REQ-012 SHALL have ports set_stb/set_addr/set_data  output  1/ADDR_W/DATA_W  registered setting-bus write to decoder.
REQ-013 SHALL have port grant_id  output  1  requester of the most recent strobe.
REQ-014 SHALL have port write_count  output  16  saturating count of issued strobes.

Function
REQ-015 SHALL implement states S_IDLE, S_ISSUE, S_GAP.
REQ-016 Accept SHALL occur only in S_IDLE with enable=1; accept = valid & ready of one requester; ready is combinational from state, enable, valids, busy, pointer.
REQ-017 Eligibility: req0 iff req0_valid & !busy; req1 iff req1_valid.
REQ-018 One eligible -> grant it; both eligible -> round-robin, grant the requester not granted last; after reset req0 wins first tie.
REQ-019 At most one ready high per cycle; ready SHALL never assert for an ineligible requester.
REQ-020 Accept in cycle N: addr/data/grant_id captured, set_stb=1 in cycle N+1 only (exactly one cycle), state S_ISSUE in N+1.
REQ-021 S_ISSUE -> S_GAP if GAP>0, else S_IDLE; S_GAP counts GAP cycles then -> S_IDLE; minimum strobe spacing GAP+2 cycles.
REQ-022 set_addr/set_data/grant_id SHALL hold last issued values until next issue.
REQ-023 write_count increments on each set_stb, saturates at 0xFFFF, no wrap.
REQ-024 enable=0 SHALL block new accepts only; an in-flight S_ISSUE/S_GAP completes normally.
REQ-025 busy rising while req0 pending SHALL defer req0 indefinitely; req1 unaffected; busy change after accept SHALL not cancel the issued write.
REQ-026 Valid deasserted before accept SHALL be dropped silently; requesters hold addr/data stable while valid.
REQ-027 Round-robin pointer SHALL update only on accept.

Reset
REQ-028 reset=0 SHALL immediately force S_IDLE, gap counter 0, set_stb 0, set_addr 0, set_data 0, grant_id 0, write_count 0, pointer = "last granted req1", both ready 0.
REQ-029 Reset asserted mid-S_ISSUE SHALL abort the strobe the same instant; no strobe after release until a new accept.

Verification
REQ-030 Single write: req0 addr 0x01 data 0 at cycle N, busy 0 -> req0_ready at N, set_stb at N+1 with 0x01/0, grant_id 0, write_count 1.
REQ-031 Contention: both valid continuously, GAP=2 -> strobes every 4 cycles alternating req0,req1,req0; write_count 3 after third.
REQ-032 Busy defer: busy=1, req0 and req1 valid -> req1 served, req0_ready stays 0; busy=0 -> req0 served next idle cycle.
REQ-033 GAP=0: two back-to-back req1 writes -> strobes exactly 2 cycles apart.
REQ-034 Reset mid-issue: reset=0 during set_stb=1 -> set_stb 0 immediately, all outputs at reset values, write_count 0.
REQ-035 Saturation: force 65537 writes -> write_count holds 0xFFFF.
